// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, port IDs, memory geometry.
package dmem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned MEM_WORDS  = 32;
  localparam int unsigned MEM_IDX_HI = 6;
  localparam int unsigned NUM_PORTS  = 2;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-requester select: round-robin against the last grant,
// or port 0 always wins a tie when FIXED_PRI is set.
module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid_c,
  output logic       win_c
);

  // Pick the winning port for the current request pair
  always_comb begin
    valid_c = |req;
    win_c   = PORT0;
    case (req)
      2'b01:   win_c = PORT0;
      2'b10:   win_c = PORT1;
      2'b11:   win_c = (FIXED_PRI != 0) ? PORT0 : ~last;
      default: win_c = PORT0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported 32-word data memory.
// One access per three cycles: IDLE (arbitrate/latch), ACCESS (drive memory), RESP (ack).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              p0_stall
);

  // Misaligned or beyond the last memory word
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:MEM_IDX_HI+1] != '0);
  endfunction

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              cmd_port_q, cmd_port_d;
  logic              cmd_we_q, cmd_we_d;
  logic              cmd_err_q, cmd_err_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic              arb_valid_c;
  logic              arb_win_c;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_access;

  rr_arb2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_rr_arb2 (
    .req     ({p1_req, p0_req}),
    .last    (last_q),
    .valid_c (arb_valid_c),
    .win_c   (arb_win_c)
  );

  // Winner's command fields
  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (arb_win_c == PORT1) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_err_d   = cmd_err_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ack_d       = 2'b00;
    err_d       = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_c) begin
          state_d     = ACCESS;
          cmd_port_d  = arb_win_c;
          cmd_we_d    = sel_we;
          cmd_err_d   = addr_bad(sel_addr);
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
        end
      end
      ACCESS: begin
        state_d             = RESP;
        ack_d[cmd_port_q]   = 1'b1;
        err_d[cmd_port_q]   = cmd_err_q;
        if (cmd_err_q) begin
          if (cmd_port_q == PORT1) rdata1_d = '0;
          else                     rdata0_d = '0;
        end else if (!cmd_we_q) begin
          if (cmd_port_q == PORT1) rdata1_d = mem_rd_data;
          else                     rdata0_d = mem_rd_data;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = cmd_port_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= PORT1;
      cmd_port_q  <= PORT0;
      cmd_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ack_q       <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_err_q   <= cmd_err_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  // Memory side is live only in ACCESS; gating on the state register makes the
  // enables fall as soon as reset asserts
  assign in_access   = (state_q == ACCESS);
  assign mem_addr    = in_access ? cmd_addr_q : '0;
  assign mem_wr_data = in_access ? cmd_wdata_q : '0;
  assign mem_rd_en   = in_access & ~cmd_we_q & ~cmd_err_q;
  assign mem_wr_en   = in_access &  cmd_we_q & ~cmd_err_q;

  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p0_err   = err_q[0];
  assign p1_err   = err_q[1];
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;
  assign busy     = busy_q;
  assign p0_stall = p0_req & ~ack_q[0];

endmodule
